// File: rtl/axi_tg_pkg.sv
// Shared types and constants for the AXI4 master traffic generator.
// The data pattern is the 32-bit beat address XOR seed, replicated to the widest supported bus.
package axi_tg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_DONE
    } tg_state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR = 2'b01;

    localparam int ID_W      = 4;
    localparam int PAT_MAX_W = 256;

    // Callers truncate to their own DATA_W; the replication keeps every 32-bit lane identical.
    function automatic logic [PAT_MAX_W-1:0] pattern(input logic [31:0] addr,
                                                     input logic [31:0] seed);
        return {(PAT_MAX_W/32){addr ^ seed}};
    endfunction

endpackage

// File: rtl/axi_mst_traffic_gen_if.sv
// AXI4 full bus bundle between the traffic generator (master) and the block under test (slave).
interface axi_mst_traffic_gen_if
    import axi_tg_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) ();

    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_tg_beat_ctr.sv
// Beat counter for one burst: cleared by load, advanced by an accepted handshake,
// flags the beat that must carry LAST.
module axi_tg_beat_ctr #(
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             inc,
    input  logic [CNT_W-1:0] last_idx,
    output logic [CNT_W-1:0] count,
    output logic             is_last
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign is_last = (count_q == last_idx);

endmodule

// File: rtl/axi_mst_traffic_gen.sv
// Synthesizable AXI4 master: writes cfg_num INCR bursts of an address-derived pattern,
// reads them back one burst at a time and counts data/response/RLAST errors.
module axi_mst_traffic_gen
    import axi_tg_pkg::*;
#(
    parameter int          ADDR_W     = 32,
    parameter int          DATA_W     = 64,
    parameter int          MAX_LEN    = 16,
    parameter int          MAX_BURSTS = 256,
    parameter logic [31:0] SEED       = 32'hA5A5_0000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [ADDR_W-1:0]             cfg_base,
    input  logic [$clog2(MAX_LEN):0]      cfg_len,
    input  logic [$clog2(MAX_BURSTS):0]   cfg_num,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic [15:0]                   err_count,
    output logic [ADDR_W-1:0]             first_err_addr,
    axi_mst_traffic_gen_if.master         m_axi
);

    localparam int BYTES = DATA_W / 8;
    localparam int LEN_W = $clog2(MAX_LEN) + 1;
    localparam int NUM_W = $clog2(MAX_BURSTS) + 1;
    localparam logic [2:0] AXI_SIZE = 3'($clog2(BYTES));

    tg_state_e          state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [NUM_W-1:0]   num_q, num_d;
    logic [NUM_W-1:0]   b_q, b_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [ADDR_W-1:0]  burst_addr_q, burst_addr_d;
    logic               aw_done_q, aw_done_d;
    logic               w_done_q, w_done_d;
    logic [15:0]        err_count_q, err_count_d;
    logic [ADDR_W-1:0]  first_err_addr_q, first_err_addr_d;

    logic [LEN_W-1:0]   len_clamped;
    logic [LEN_W-1:0]   last_idx;
    logic [ADDR_W-1:0]  burst_step;
    logic               last_burst;
    logic               wr_active;

    logic [LEN_W-1:0]   w_count, r_count;
    logic               w_last, r_last;
    logic [ADDR_W-1:0]  w_beat_addr, r_beat_addr;
    logic [DATA_W-1:0]  w_pattern, r_pattern;

    logic               aw_hs, w_hs, r_hs;
    logic               err_hit;
    logic [ADDR_W-1:0]  err_addr;

    assign len_clamped = ((cfg_len == '0) || (cfg_len > LEN_W'(MAX_LEN))) ? LEN_W'(MAX_LEN) : cfg_len;
    assign last_idx    = len_q - LEN_W'(1);
    assign burst_step  = ADDR_W'(len_q) * ADDR_W'(BYTES);
    assign last_burst  = (b_q == num_q - NUM_W'(1));
    assign wr_active   = (state_q == ST_WR_REQ) && (num_q != '0);

    assign w_beat_addr = burst_addr_q + ADDR_W'(w_count) * ADDR_W'(BYTES);
    assign r_beat_addr = burst_addr_q + ADDR_W'(r_count) * ADDR_W'(BYTES);
    assign w_pattern   = DATA_W'(pattern(32'(w_beat_addr), SEED));
    assign r_pattern   = DATA_W'(pattern(32'(r_beat_addr), SEED));

    assign aw_hs = m_axi.awvalid && m_axi.awready;
    assign w_hs  = m_axi.wvalid  && m_axi.wready;
    assign r_hs  = m_axi.rvalid  && m_axi.rready;

    axi_tg_beat_ctr #(.CNT_W(LEN_W)) u_w_ctr (
        .clock    (clock),
        .reset    (reset),
        .load     (state_q != ST_WR_REQ),
        .inc      (w_hs && !w_last),
        .last_idx (last_idx),
        .count    (w_count),
        .is_last  (w_last)
    );

    axi_tg_beat_ctr #(.CNT_W(LEN_W)) u_r_ctr (
        .clock    (clock),
        .reset    (reset),
        .load     (state_q != ST_RD_DATA),
        .inc      (r_hs && !r_last),
        .last_idx (last_idx),
        .count    (r_count),
        .is_last  (r_last)
    );

    always_comb begin
        state_d          = state_q;
        len_d            = len_q;
        num_d            = num_q;
        b_d              = b_q;
        base_d           = base_q;
        burst_addr_d     = burst_addr_q;
        aw_done_d        = aw_done_q;
        w_done_d         = w_done_q;
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;
        err_hit          = 1'b0;
        err_addr         = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d            = len_clamped;
                    num_d            = cfg_num;
                    base_d           = cfg_base;
                    burst_addr_d     = cfg_base;
                    b_d              = '0;
                    err_count_d      = '0;
                    first_err_addr_d = '0;
                    state_d          = ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                if (num_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    // AW and W complete independently; leave only once both sides are through.
                    if (aw_hs) aw_done_d = 1'b1;
                    if (w_hs && w_last) w_done_d = 1'b1;
                    if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && w_last))) begin
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = ST_WR_RESP;
                    end
                end
            end
            ST_WR_RESP: begin
                if (m_axi.bvalid) begin
                    if (m_axi.bresp != OKAY) begin
                        err_hit  = 1'b1;
                        err_addr = burst_addr_q;
                    end
                    if (last_burst) begin
                        b_d          = '0;
                        burst_addr_d = base_q;
                        state_d      = ST_RD_REQ;
                    end else begin
                        b_d          = b_q + NUM_W'(1);
                        burst_addr_d = burst_addr_q + burst_step;
                        state_d      = ST_WR_REQ;
                    end
                end
            end
            ST_RD_REQ: begin
                if (m_axi.arready) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (m_axi.rvalid) begin
                    if ((m_axi.rdata != r_pattern) || (m_axi.rresp != OKAY) ||
                        (m_axi.rlast != r_last)) begin
                        err_hit  = 1'b1;
                        err_addr = r_beat_addr;
                    end
                    if (r_last) begin
                        if (last_burst) begin
                            state_d = ST_DONE;
                        end else begin
                            b_d          = b_q + NUM_W'(1);
                            burst_addr_d = burst_addr_q + burst_step;
                            state_d      = ST_RD_REQ;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (err_hit) begin
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
            if (err_count_q == 16'd0) first_err_addr_d = err_addr;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            len_q            <= '0;
            num_q            <= '0;
            b_q              <= '0;
            base_q           <= '0;
            burst_addr_q     <= '0;
            aw_done_q        <= 1'b0;
            w_done_q         <= 1'b0;
            err_count_q      <= '0;
            first_err_addr_q <= '0;
        end else begin
            state_q          <= state_d;
            len_q            <= len_d;
            num_q            <= num_d;
            b_q              <= b_d;
            base_q           <= base_d;
            burst_addr_q     <= burst_addr_d;
            aw_done_q        <= aw_done_d;
            w_done_q         <= w_done_d;
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
        end
    end

    assign m_axi.awid    = '0;
    assign m_axi.awaddr  = burst_addr_q;
    assign m_axi.awlen   = 8'(len_q - LEN_W'(1));
    assign m_axi.awsize  = AXI_SIZE;
    assign m_axi.awburst = BURST_INCR;
    assign m_axi.awvalid = wr_active && !aw_done_q;

    assign m_axi.wdata   = w_pattern;
    assign m_axi.wstrb   = '1;
    assign m_axi.wlast   = w_last;
    assign m_axi.wvalid  = wr_active && !w_done_q;

    assign m_axi.bready  = (state_q == ST_WR_RESP);

    assign m_axi.arid    = '0;
    assign m_axi.araddr  = burst_addr_q;
    assign m_axi.arlen   = 8'(len_q - LEN_W'(1));
    assign m_axi.arsize  = AXI_SIZE;
    assign m_axi.arburst = BURST_INCR;
    assign m_axi.arvalid = (state_q == ST_RD_REQ);

    assign m_axi.rready  = (state_q == ST_RD_DATA);

    assign busy           = (state_q == ST_WR_REQ) || (state_q == ST_WR_RESP) ||
                            (state_q == ST_RD_REQ) || (state_q == ST_RD_DATA);
    assign done           = (state_q == ST_DONE);
    assign pass           = done && (err_count_q == 16'd0);
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;

endmodule

// File: tb/tb_axi_mst_traffic_gen.sv
// Directed bench for axi_mst_traffic_gen: a memory slave with optional stalls and
// injected faults, checked against hand-computed addresses, counts and patterns.
module tb_axi_mst_traffic_gen;

    localparam int          ADDR_W = 32;
    localparam int          DATA_W = 64;
    localparam logic [31:0] SEED   = 32'hA5A5_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] cfg_base;
    logic [4:0]  cfg_len;
    logic [8:0]  cfg_num;
    logic        busy, done, pass;
    logic [15:0] err_count;
    logic [31:0] first_err_addr;

    axi_mst_traffic_gen_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

    axi_mst_traffic_gen #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LEN(16), .MAX_BURSTS(256), .SEED(SEED)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .cfg_base       (cfg_base),
        .cfg_len        (cfg_len),
        .cfg_num        (cfg_num),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .m_axi          (axi)
    );

    always #5 clock = ~clock;

    int check_count = 0;
    int pass_count  = 0;

    logic        clr_stats = 1'b0;
    logic        stall_en = 1'b0;
    logic [31:0] exp_base = '0;
    int          exp_len = 1;
    int          flt_bresp_burst = -1;
    int          flt_rlast_burst = -1;
    logic        flt_rdata_en = 1'b0;
    logic [31:0] flt_rdata_addr = '0;

    logic [DATA_W-1:0] mem [logic [31:0]];
    logic [DATA_W-1:0] wbuf [$];
    logic [31:0]       aw_log [$];

    int aw_cnt, w_cnt, ar_cnt, r_cnt, b_cnt, done_cnt;
    int awlen_err, wdat_err, wlast_err, stab_err;

    logic        aw_have, wlast_seen, rd_active;
    logic [31:0] aw_addr_s, rd_addr;
    int          rd_len, rd_beat, wr_burst, rd_burst;
    logic        aw_pend, w_pend, ar_pend;
    logic [31:0] aw_pend_addr, ar_pend_addr;
    logic [DATA_W-1:0] w_pend_data;
    logic        w_pend_last;

    logic        n_aw_have, n_wlast_seen, n_rd_active, r_hs;
    logic [31:0] n_aw_addr, n_rd_addr, exp_addr, rd_beat_addr;
    int          n_rd_len, n_rd_beat, n_rd_burst;
    logic [DATA_W-1:0] rv;

    logic        done_pass;
    logic [15:0] done_err;
    logic [31:0] done_first;

    function automatic logic rnd_ready();
        return !stall_en || ($urandom_range(0, 3) == 0);
    endfunction

    // Memory slave plus protocol monitor; one outstanding burst per direction.
    always @(posedge clock) begin
        if (reset || clr_stats) begin
            axi.awready <= 1'b0; axi.wready <= 1'b0; axi.bvalid <= 1'b0; axi.bresp <= 2'b00;
            axi.arready <= 1'b0; axi.rvalid <= 1'b0; axi.rdata <= '0;
            axi.rresp <= 2'b00; axi.rlast <= 1'b0;
            aw_have <= 1'b0; wlast_seen <= 1'b0; rd_active <= 1'b0; aw_addr_s <= '0;
            rd_addr <= '0; rd_len <= 0; rd_beat <= 0; wr_burst <= 0; rd_burst <= 0;
            wbuf.delete();
            aw_log.delete();
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0; b_cnt <= 0; done_cnt <= 0;
            awlen_err <= 0; wdat_err <= 0; wlast_err <= 0; stab_err <= 0;
            aw_pend <= 1'b0; w_pend <= 1'b0; ar_pend <= 1'b0;
        end else begin
            if (aw_pend && (!axi.awvalid || axi.awaddr != aw_pend_addr)) stab_err <= stab_err + 1;
            if (w_pend && (!axi.wvalid || axi.wdata != w_pend_data || axi.wlast != w_pend_last))
                stab_err <= stab_err + 1;
            if (ar_pend && (!axi.arvalid || axi.araddr != ar_pend_addr)) stab_err <= stab_err + 1;
            aw_pend <= axi.awvalid && !axi.awready; aw_pend_addr <= axi.awaddr;
            w_pend  <= axi.wvalid && !axi.wready;   w_pend_data <= axi.wdata; w_pend_last <= axi.wlast;
            ar_pend <= axi.arvalid && !axi.arready; ar_pend_addr <= axi.araddr;
            if (done) done_cnt <= done_cnt + 1;

            n_aw_have = aw_have; n_aw_addr = aw_addr_s; n_wlast_seen = wlast_seen;
            if (axi.awvalid && axi.awready) begin
                n_aw_have = 1'b1;
                n_aw_addr = axi.awaddr;
                aw_cnt <= aw_cnt + 1;
                aw_log.push_back(axi.awaddr);
                if (axi.awlen != 8'(exp_len - 1)) awlen_err <= awlen_err + 1;
            end
            if (axi.wvalid && axi.wready) begin
                wbuf.push_back(axi.wdata);
                exp_addr = exp_base + 32'(w_cnt) * 32'd8;
                if (axi.wdata != {2{exp_addr ^ SEED}}) wdat_err <= wdat_err + 1;
                if (axi.wlast != ((w_cnt % exp_len) == exp_len - 1)) wlast_err <= wlast_err + 1;
                if (axi.wlast) n_wlast_seen = 1'b1;
                w_cnt <= w_cnt + 1;
            end
            if (axi.bvalid && axi.bready) begin
                axi.bvalid <= 1'b0;
                b_cnt <= b_cnt + 1;
            end else if (!axi.bvalid && n_aw_have && n_wlast_seen) begin
                foreach (wbuf[i]) mem[n_aw_addr + 32'(i) * 32'd8] = wbuf[i];
                wbuf.delete();
                axi.bvalid <= 1'b1;
                axi.bresp  <= (wr_burst == flt_bresp_burst) ? 2'b10 : 2'b00;
                wr_burst   <= wr_burst + 1;
                n_aw_have = 1'b0;
                n_wlast_seen = 1'b0;
            end
            axi.awready <= !n_aw_have && rnd_ready();
            axi.wready  <= !n_wlast_seen && rnd_ready();
            aw_have <= n_aw_have; aw_addr_s <= n_aw_addr; wlast_seen <= n_wlast_seen;

            n_rd_active = rd_active; n_rd_addr = rd_addr; n_rd_len = rd_len;
            n_rd_beat = rd_beat; n_rd_burst = rd_burst;
            r_hs = axi.rvalid && axi.rready;
            if (r_hs) begin
                r_cnt <= r_cnt + 1;
                n_rd_beat = rd_beat + 1;
                if (n_rd_beat == rd_len) begin
                    n_rd_active = 1'b0;
                    n_rd_burst = rd_burst + 1;
                end
            end
            if (axi.arvalid && axi.arready) begin
                n_rd_active = 1'b1;
                n_rd_addr = axi.araddr;
                n_rd_len = int'(axi.arlen) + 1;
                n_rd_beat = 0;
                ar_cnt <= ar_cnt + 1;
            end
            if (n_rd_active && (!axi.rvalid || r_hs)) begin
                if (rnd_ready()) begin
                    rd_beat_addr = n_rd_addr + 32'(n_rd_beat) * 32'd8;
                    rv = mem.exists(rd_beat_addr) ? mem[rd_beat_addr] : '0;
                    if (flt_rdata_en && rd_beat_addr == flt_rdata_addr) rv = rv ^ 64'h1;
                    axi.rvalid <= 1'b1;
                    axi.rdata  <= rv;
                    axi.rresp  <= 2'b00;
                    axi.rlast  <= (n_rd_beat == n_rd_len - 1) ||
                                  (n_rd_burst == flt_rlast_burst && n_rd_beat == n_rd_len - 2);
                end else begin
                    axi.rvalid <= 1'b0;
                end
            end else if (!n_rd_active) begin
                axi.rvalid <= 1'b0;
            end
            axi.arready <= !n_rd_active && rnd_ready();
            rd_active <= n_rd_active; rd_addr <= n_rd_addr; rd_len <= n_rd_len;
            rd_beat <= n_rd_beat; rd_burst <= n_rd_burst;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        else
            pass_count++;
    endtask

    task automatic applyStimulus(input logic [31:0] base, input logic [4:0] len, input logic [8:0] num);
        @(negedge clock);
        cfg_base = base; cfg_len = len; cfg_num = num;
        exp_base = base; exp_len = int'(len);
        clr_stats = 1'b1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        clr_stats = 1'b0;
    endtask

    task automatic waitDone(input int limit);
        int n;
        n = 0;
        while (!done && n < limit) begin
            @(negedge clock);
            n++;
        end
        if (!done) checkOutput("done_timeout", 64'd0, 64'd1);
        done_pass  = pass;
        done_err   = err_count;
        done_first = first_err_addr;
    endtask

    initial begin
        int n;
        logic [31:0] log0, log1;
        reset = 1'b1; start = 1'b0;
        cfg_base = '0; cfg_len = 5'd1; cfg_num = 9'd1;
        repeat (3) @(negedge clock);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_pass", 64'(pass), 64'd0);
        checkOutput("rst_err", 64'(err_count), 64'd0);
        checkOutput("rst_first", 64'(first_err_addr), 64'd0);
        checkOutput("rst_valids", 64'({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}), 64'd0);
        reset = 1'b0;

        $display("[TB] basic zero-wait run");
        applyStimulus(32'h1000, 5'd4, 9'd2);
        waitDone(500);
        log0 = (aw_log.size() > 0) ? aw_log[0] : 32'hDEAD_BEEF;
        log1 = (aw_log.size() > 1) ? aw_log[1] : 32'hDEAD_BEEF;
        checkOutput("basic_pass", 64'(done_pass), 64'd1);
        checkOutput("basic_err", 64'(done_err), 64'd0);
        checkOutput("basic_aw_cnt", 64'(aw_cnt), 64'd2);
        checkOutput("basic_aw0", 64'(log0), 64'h1000);
        checkOutput("basic_aw1", 64'(log1), 64'h1020);
        checkOutput("basic_awlen", 64'(awlen_err), 64'd0);
        checkOutput("basic_handshakes", 64'(w_cnt + r_cnt), 64'd16);
        checkOutput("basic_ar_cnt", 64'(ar_cnt), 64'd2);
        checkOutput("basic_wdata", 64'(wdat_err + wlast_err), 64'd0);
        checkOutput("basic_mem_1000", mem.exists(32'h1000) ? mem[32'h1000] : 64'd0, 64'hA5A51000_A5A51000);
        checkOutput("basic_mem_1038", mem.exists(32'h1038) ? mem[32'h1038] : 64'd0, 64'hA5A51038_A5A51038);

        $display("[TB] stalled run, 8 x 16 beats");
        stall_en = 1'b1;
        applyStimulus(32'h2000, 5'd16, 9'd8);
        waitDone(20000);
        checkOutput("stall_pass", 64'(done_pass), 64'd1);
        checkOutput("stall_err", 64'(done_err), 64'd0);
        checkOutput("stall_stable", 64'(stab_err), 64'd0);
        checkOutput("stall_wdata", 64'(wdat_err), 64'd0);
        checkOutput("stall_wlast", 64'(wlast_err), 64'd0);
        checkOutput("stall_w_cnt", 64'(w_cnt), 64'd128);
        checkOutput("stall_r_cnt", 64'(r_cnt), 64'd128);
        stall_en = 1'b0;

        $display("[TB] corrupted read data at 0x1028");
        flt_rdata_en = 1'b1; flt_rdata_addr = 32'h1028;
        applyStimulus(32'h1000, 5'd4, 9'd2);
        waitDone(500);
        checkOutput("rdata_err", 64'(done_err), 64'd1);
        checkOutput("rdata_first", 64'(done_first), 64'h1028);
        checkOutput("rdata_pass", 64'(done_pass), 64'd0);
        flt_rdata_en = 1'b0;

        $display("[TB] SLVERR on burst 1 plus early RLAST");
        flt_bresp_burst = 1; flt_rlast_burst = 0;
        applyStimulus(32'h1000, 5'd4, 9'd2);
        waitDone(500);
        checkOutput("resp_err", 64'(done_err), 64'd2);
        checkOutput("resp_first", 64'(done_first), 64'h1020);
        checkOutput("resp_pass", 64'(done_pass), 64'd0);
        flt_rlast_burst = -1;

        $display("[TB] reset during burst 3 write");
        flt_bresp_burst = 1;
        applyStimulus(32'h1000, 5'd4, 9'd8);
        n = 0;
        while (!(axi.awvalid && axi.awaddr == 32'h1060) && n < 500) begin
            @(negedge clock);
            n++;
        end
        checkOutput("abort_burst3_seen", 64'(axi.awvalid && axi.awaddr == 32'h1060), 64'd1);
        checkOutput("abort_err_before", 64'(err_count), 64'd1);
        flt_bresp_burst = -1;
        reset = 1'b1;
        @(negedge clock);
        checkOutput("abort_valids", 64'({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}), 64'd0);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_err", 64'(err_count), 64'd0);
        reset = 1'b0;
        applyStimulus(32'h3000, 5'd4, 9'd2);
        waitDone(500);
        checkOutput("abort_rerun_pass", 64'(done_pass), 64'd1);

        $display("[TB] zero bursts");
        @(negedge clock);
        cfg_num = 9'd0; cfg_base = 32'h4000; cfg_len = 5'd4;
        clr_stats = 1'b1; start = 1'b1;
        @(negedge clock);
        start = 1'b0; clr_stats = 1'b0;
        checkOutput("zero_done_early", 64'(done), 64'd0);
        @(negedge clock);
        checkOutput("zero_done", 64'(done), 64'd1);
        checkOutput("zero_pass", 64'(pass), 64'd1);
        checkOutput("zero_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clock);
        checkOutput("zero_no_traffic", 64'(aw_cnt + ar_cnt), 64'd0);
        checkOutput("zero_done_cnt", 64'(done_cnt), 64'd1);

        $display("[TB] start while busy");
        applyStimulus(32'h1000, 5'd4, 9'd2);
        repeat (3) @(negedge clock);
        cfg_base = 32'h8000; cfg_num = 9'd5; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        waitDone(500);
        log0 = (aw_log.size() > 0) ? aw_log[0] : 32'hDEAD_BEEF;
        checkOutput("busy_start_pass", 64'(done_pass), 64'd1);
        checkOutput("busy_start_aw_cnt", 64'(aw_cnt), 64'd2);
        checkOutput("busy_start_aw0", 64'(log0), 64'h1000);
        repeat (5) @(negedge clock);
        checkOutput("busy_start_done_cnt", 64'(done_cnt), 64'd1);
        checkOutput("busy_start_idle", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/axi_mst_traffic_gen.md
Name: axi_mst_traffic_gen

Overview:
- Synthesizable, parametrised AXI4 full master that replaces the simulation-only master VIP stimulus in chip-level benches and on-board bring-up.
- Writes a configurable number of INCR bursts of a deterministic pattern, then reads them back and self-checks data, response codes and RLAST.
- Drives the slave side of the block design directly, or through a passthrough VIP; reports pass/fail via status ports.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 64, AXI data width (32/64/128/256).
- MAX_LEN, 16, max beats per burst (power of 2, ≤256).
- MAX_BURSTS, 256, max bursts per run; sizes the burst counter.
- SEED, 32'hA5A5_0000, pattern seed XORed into every data word.

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse starting a run; ignored while busy
- cfg_base  in  ADDR_W  first burst address; must be aligned to DATA_W/8
- cfg_len  in  $clog2(MAX_LEN)+1  beats per burst, 1..MAX_LEN; sampled at start
- cfg_num  in  $clog2(MAX_BURSTS)+1  bursts per run, 1..MAX_BURSTS; sampled at start
- busy  out  1  high from cycle after start until done
- done  out  1  one-cycle pulse at run end
- pass  out  1  valid while done=1: err_count==0
- err_count  out  16  saturating error count for current/last run
- first_err_addr  out  ADDR_W  beat address of first error
- m_axi_aw{id,addr,len,size,burst,valid}/awready  out/in  AXI4 write address; id=0, burst=INCR, size=log2(DATA_W/8)
- m_axi_w{data,strb,last,valid}/wready  out/in  AXI4 write data; strb all ones
- m_axi_b{resp,valid}/bready  in/out  AXI4 write response
- m_axi_ar{id,addr,len,size,burst,valid}/arready  out/in  AXI4 read address
- m_axi_r{data,resp,last,valid}/rready  in/out  AXI4 read data

Behaviour:
- Reset: all *valid, bready, rready, busy, done, pass = 0; err_count = 0; first_err_addr = 0; FSM = IDLE. Reset mid-run aborts immediately; valids drop the next edge with no completion of outstanding bursts.
- FSM states: IDLE -> WR_REQ -> WR_RESP -> (next burst: WR_REQ | last: RD_REQ) -> RD_DATA -> (next: RD_REQ | last: DONE) -> IDLE.
- start in IDLE: latch cfg_*; clear err_count and first_err_addr; burst index b = 0. Next cycle: busy = 1, FSM = WR_REQ.
- Burst address: A_b = cfg_base + b*cfg_len*(DATA_W/8), computed modulo 2^ADDR_W. The caller guarantees no 4 KB crossing.
- Beat k data: D = {DATA_W/32 copies of (A_b + k*(DATA_W/8)) XOR SEED} — the 32-bit beat address, replicated.
- WR_REQ:
  - awvalid and wvalid are asserted in the same cycle; W does not wait for AW.
  - Each valid holds, with stable payload, until its own ready. The beat counter advances on wvalid&wready.
  - wlast is asserted on beat cfg_len-1.
  - Leave for WR_RESP once both AW has handshaked and the last W beat has handshaked.
- WR_RESP: bready = 1. On bvalid, bresp != OKAY -> error recorded at A_b. Then b++.
- RD_REQ: arvalid is held until arready. At most one burst is outstanding at any time.
- RD_DATA: rready = 1 continuously. Each rvalid beat k is one error if any of the following holds (multiple faults on one beat still count once):
  - rdata != D
  - rresp != OKAY
  - rlast != (k == cfg_len-1)
  After the expected last beat, return to RD_REQ or DONE. Any extra beats are not consumed.
- Error recording: err_count saturates at 16'hFFFF. first_err_addr is written only when err_count was 0.
- DONE: done = 1 and pass = (err_count == 0) for one cycle; busy = 0 in the same cycle; FSM returns to IDLE. err_count holds until the next start.
- Latency:
  - Minimum per write burst: 1 (AW/W) + cfg_len - 1 + 1 (B) cycles, with a zero-wait slave.
  - Read side: 1 + cfg_len cycles.
- Illegal config:
  - cfg_len = 0 or > MAX_LEN is clamped to MAX_LEN.
  - cfg_num = 0 completes immediately: done pulse, pass = 1, no bus traffic.

Decomposition:
- Package axi_tg_pkg:
  - typedef for FSM state enum.
  - resp constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - constant BURST_INCR = 2'b01.
  - function pattern(addr, seed) returning one DATA_W word.
- Sub-module axi_tg_beat_ctr: beat counter with load, increment-on-handshake and last-flag. Instantiated once for W and once for R.

Test Plan:
- Memory slave, zero wait, cfg_base=0x1000, cfg_len=4, cfg_num=2 -> AW addrs 0x1000, 0x1020, awlen=3; 16 handshakes total; done with pass=1, err_count=0.
- Slave with random awready/wready/arready/rvalid stalls (0-5 cycles), cfg_len=16, cfg_num=8 -> payload stable under stall; pass=1.
- Slave corrupts rdata at beat address 0x1028 -> err_count=1, first_err_addr=0x1028, pass=0.
- Slave returns bresp=SLVERR on burst 1 and rlast early on a read -> err_count=2, first_err_addr=0x1020.
- reset asserted during WR_REQ of burst 3 -> next cycle all valids=0, busy=0, err_count=0; a following start runs to pass=1.
- cfg_num=0 -> done on the second cycle after start, no AW/AR issued; start pulsed while busy -> ignored.
